// File: rtl/match_monitor.sv
// rtl/match_monitor.sv - compares two words per sample, tracks match streak/total, raises alarm on lock
module match_monitor #(
  parameter int unsigned W         = 3,
  parameter int unsigned STREAK_TH = 3
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] s1,
  input  logic [W-1:0] s2,
  output logic         match,
  output logic [W-1:0] diff,
  output logic [3:0]   streak,
  output logic [7:0]   total,
  output logic         alarm
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] TRACK = 2'd1;
  localparam logic [1:0] LOCK  = 2'd2;

  localparam logic [3:0] STREAK_MAX = 4'd15;
  localparam logic [7:0] TOTAL_MAX  = 8'd255;
  localparam logic [3:0] LOCK_AT    = 4'(STREAK_TH);

  logic [1:0]   state, state_d;
  logic         match_d;
  logic [W-1:0] diff_d;
  logic [3:0]   streak_d;
  logic [7:0]   total_d;
  logic         words_eq;
  logic         sampling;

  assign words_eq = (s1 == s2);
  // Only TRACK and LOCK sample; the IDLE->TRACK edge is a warm-up edge.
  assign sampling = (state == TRACK) || (state == LOCK);

  // Next-state and next-output computation; clr outranks en, en outranks sampling.
  always_comb begin
    state_d  = state;
    match_d  = match;
    diff_d   = diff;
    streak_d = streak;
    total_d  = total;
    if (clr) begin
      state_d  = IDLE;
      match_d  = 1'b0;
      diff_d   = '0;
      streak_d = '0;
      total_d  = '0;
    end else if (!en) begin
      // Dropping enable abandons the streak but keeps the lifetime total.
      state_d  = IDLE;
      match_d  = 1'b0;
      diff_d   = '0;
      streak_d = '0;
    end else if (!sampling) begin
      // IDLE (or an unreachable encoding) only arms the monitor this edge.
      state_d = TRACK;
    end else begin
      match_d = words_eq;
      diff_d  = s1 ^ s2;
      if (words_eq) begin
        streak_d = (streak == STREAK_MAX) ? streak : streak + 4'd1;
        total_d  = (total == TOTAL_MAX) ? total : total + 8'd1;
        if ((state == TRACK) && (streak_d == LOCK_AT)) begin
          state_d = LOCK;
        end
      end else begin
        streak_d = '0;
        state_d  = TRACK;
      end
    end
  end

  // State and output registers; reset clears everything without a clock.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      match  <= 1'b0;
      diff   <= '0;
      streak <= '0;
      total  <= '0;
      alarm  <= 1'b0;
    end else begin
      state  <= state_d;
      match  <= match_d;
      diff   <= diff_d;
      streak <= streak_d;
      total  <= total_d;
      // Decoded from the next state so alarm rises with the locking streak value.
      alarm  <= (state_d == LOCK);
    end
  end

endmodule

// File: tb/tb_match_monitor.sv
// tb/tb_match_monitor.sv - self-checking bench for match_monitor
module tb_match_monitor;

  localparam int W  = 3;
  localparam int TH = 3;

  logic         clk;
  logic         rstn;
  logic         en;
  logic         clr;
  logic [W-1:0] s1;
  logic [W-1:0] s2;
  logic         match;
  logic [W-1:0] diff;
  logic [3:0]   streak;
  logic [7:0]   total;
  logic         alarm;

  int checks = 0;
  int errors = 0;

  // reference model state, in plain integers
  bit m_active;
  int m_match, m_diff, m_streak, m_total;

  typedef struct {
    logic         en;
    logic         clr;
    logic [W-1:0] s1;
    logic [W-1:0] s2;
    logic         m;
    logic [W-1:0] d;
    int           st;
    int           tot;
    logic         al;
  } vec_t;

  vec_t tbl [17];

  match_monitor #(.W(W), .STREAK_TH(TH)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .en     (en),
    .clr    (clr),
    .s1     (s1),
    .s2     (s2),
    .match  (match),
    .diff   (diff),
    .streak (streak),
    .total  (total),
    .alarm  (alarm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int m, input int d, input int st,
                         input int tot, input int al);
    chk({tag, "_match"},  32'(match),  m);
    chk({tag, "_diff"},   32'(diff),   d);
    chk({tag, "_streak"}, 32'(streak), st);
    chk({tag, "_total"},  32'(total),  tot);
    chk({tag, "_alarm"},  32'(alarm),  al);
  endtask

  task automatic model_reset();
    m_active = 0;
    m_match  = 0;
    m_diff   = 0;
    m_streak = 0;
    m_total  = 0;
  endtask

  // alarm is simply "streak has reached the threshold" while active
  function automatic int model_alarm();
    return (m_active && m_streak >= TH) ? 1 : 0;
  endfunction

  task automatic model_edge(input bit e, input bit c, input int a, input int b);
    if (c) begin
      model_reset();
    end else if (!e) begin
      m_active = 0;
      m_streak = 0;
      m_match  = 0;
      m_diff   = 0;
    end else if (!m_active) begin
      m_active = 1;
    end else begin
      m_match = (a == b) ? 1 : 0;
      m_diff  = a ^ b;
      if (a == b) begin
        if (m_streak < 15)  m_streak++;
        if (m_total  < 255) m_total++;
      end else begin
        m_streak = 0;
      end
    end
  endtask

  // drive inputs, take one rising edge, advance the model, land 1 ns after the edge
  task automatic cycle(input bit e, input bit c, input int a, input int b);
    en  = e;
    clr = c;
    s1  = W'(a);
    s2  = W'(b);
    @(posedge clk);
    #1;
    model_edge(e, c, a, b);
  endtask

  task automatic chk_model(input string tag);
    chk_all(tag, m_match, m_diff, m_streak, m_total, model_alarm());
  endtask

  initial begin
    // reset with random data present
    rstn = 1'b0;
    en   = 1'b1;
    clr  = 1'b0;
    s1   = W'($urandom);
    s2   = W'($urandom);
    model_reset();
    #3;
    chk_all("rst_async", 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk_all("rst_edge", 0, 0, 0, 0, 0);
    en   = 1'b0;
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      chk_all("idle_en0", 0, 0, 0, 0, 0);
    end

    // lock, unlock, clear priority, enable drop
    tbl[0]  = '{1'b1, 1'b0, 3'd5, 3'd5, 1'b0, 3'd0, 0, 0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 3'd5, 3'd5, 1'b1, 3'd0, 1, 1, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 3'd5, 3'd5, 1'b1, 3'd0, 2, 2, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 3'd5, 3'd5, 1'b1, 3'd0, 3, 3, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 3'd5, 3'd5, 1'b1, 3'd0, 4, 4, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 3'd5, 3'd4, 1'b0, 3'd1, 0, 4, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 3'd6, 3'd6, 1'b1, 3'd0, 1, 5, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 3'd6, 3'd6, 1'b1, 3'd0, 2, 6, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 3'd6, 3'd6, 1'b1, 3'd0, 3, 7, 1'b1};
    tbl[9]  = '{1'b1, 1'b1, 3'd6, 3'd6, 1'b0, 3'd0, 0, 0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 3'd2, 3'd2, 1'b0, 3'd0, 0, 0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 3'd2, 3'd2, 1'b1, 3'd0, 1, 1, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 3'd7, 3'd3, 1'b0, 3'd4, 0, 1, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 3'd1, 3'd1, 1'b1, 3'd0, 1, 2, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 3'd1, 3'd1, 1'b0, 3'd0, 0, 2, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 3'd1, 3'd1, 1'b0, 3'd0, 0, 2, 1'b0};
    tbl[16] = '{1'b1, 1'b0, 3'd1, 3'd1, 1'b1, 3'd0, 1, 3, 1'b0};
    for (int i = 0; i < 17; i++) begin
      cycle(tbl[i].en, tbl[i].clr, int'(tbl[i].s1), int'(tbl[i].s2));
      chk_all($sformatf("vec%0d", i), int'(tbl[i].m), int'(tbl[i].d), tbl[i].st,
              tbl[i].tot, int'(tbl[i].al));
    end

    // saturation: clear, arm, then 300 matching samples
    cycle(1, 1, 0, 0);
    cycle(1, 0, 3, 3);
    for (int i = 0; i < 300; i++) begin
      cycle(1, 0, i % 8, i % 8);
      chk_model($sformatf("sat%0d", i));
    end
    chk_all("sat_end", 1, 0, 15, 255, 1);

    // async reset between edges while locked
    #2;
    rstn = 1'b0;
    #1;
    chk("async_alarm",  32'(alarm),  0);
    chk("async_streak", 32'(streak), 0);
    chk("async_total",  32'(total),  0);
    chk("async_match",  32'(match),  0);
    #1;
    rstn = 1'b1;
    model_reset();
    cycle(1, 0, 4, 4);
    chk_all("post_rst_arm", 0, 0, 0, 0, 0);
    cycle(1, 0, 4, 4);
    chk_all("post_rst_s1", 1, 0, 1, 1, 0);

    // randomized run against the reference model
    for (int i = 0; i < 2000; i++) begin
      int a, b;
      bit e, c;
      e = ($urandom_range(0, 15) != 0);
      c = ($urandom_range(0, 40) == 0);
      a = int'($urandom_range(0, 7));
      b = ($urandom_range(0, 3) != 0) ? a : int'($urandom_range(0, 7));
      cycle(e, c, a, b);
      chk_model($sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/match_monitor.md
MATCH_MONITOR -- requirements
Module: match_monitor

Interface
REQ-001 The module SHALL have parameter W, default 3, giving the width of the compared data words.
REQ-002 The module SHALL have parameter STREAK_TH, default 3, giving the consecutive-match count that raises alarm (range 1..15).
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rstn  input  1  reset, asynchronous and active-low.
REQ-005 en  input  1  monitor enable; low forces IDLE.
REQ-006 clr  input  1  synchronous clear of streak, total and state.
REQ-007 s1  input  W  first compared word from the upstream shift stage.
REQ-008 s2  input  W  second compared word from the upstream shift stage.
REQ-009 match  output  1  registered flag, s1==s2 on the last sampled cycle.
REQ-010 diff  output  W  registered s1 XOR s2 of the last sampled cycle.
REQ-011 streak  output  4  consecutive-match count, saturating at 15.
REQ-012 total  output  8  total matches since clear, saturating at 255.
REQ-013 alarm  output  1  high while the FSM is in LOCK.

Function
REQ-014 The FSM SHALL have states IDLE, TRACK and LOCK.
REQ-015 A "sample" SHALL occur on a rising edge only when the current state is TRACK or LOCK, en=1 and clr=0.
REQ-016 IDLE->TRACK SHALL occur on the first edge with en=1 and clr=0; that edge is not a sample.
REQ-017 On every sample, match and diff SHALL update from the s1/s2 values present before the edge (latency 1 cycle); they SHALL hold between samples.
REQ-018 On a matching sample, streak SHALL increment, saturating at 15, and total SHALL increment, saturating at 255.
REQ-019 On a mismatching sample, streak SHALL go to 0 and total SHALL hold.
REQ-020 TRACK->LOCK SHALL occur on the sample where the new streak value equals STREAK_TH.
REQ-021 In LOCK, matching samples SHALL keep the state in LOCK.
REQ-022 LOCK->TRACK SHALL occur on a mismatching sample.
REQ-023 alarm SHALL be a registered decode of state==LOCK, asserting in the same cycle streak first reaches STREAK_TH.
REQ-024 en=0 on an edge SHALL force IDLE and set streak=0, match=0 and diff=0; total SHALL hold.
REQ-025 clr=1 on an edge SHALL force IDLE and zero streak, total, match and diff; clr SHALL take priority over en and over a simultaneous match.
REQ-026 After clr, re-entry SHALL follow REQ-016, i.e. one non-sampling edge before the first sample.
REQ-027 At saturation (streak=15 or total=255), a further match SHALL leave the value unchanged with no wrap.
REQ-028 No combinational path SHALL exist from any input to any output.

Reset
REQ-029 rstn=0 SHALL immediately, without waiting for a clock edge, set state=IDLE, match=0, diff=0, streak=0, total=0 and alarm=0.
REQ-030 Reset asserted mid-operation (including in LOCK) SHALL abort the state with no residual counts.
REQ-031 Release of rstn SHALL take effect on the first rising edge after deassertion, with IDLE entry rules applied.

Verification
REQ-032 Reset/idle: rstn=0 with random s1/s2 -> all outputs 0; release with en=0 for 5 cycles -> outputs remain 0.
REQ-033 Lock: en=1, s1=s2=3'b101 for 5 cycles -> cycle 1 no sample; after samples 1..3 streak=1,2,3 and alarm=1 at streak=3; after sample 4 streak=4, total=4, alarm=1.
REQ-034 Unlock: from LOCK apply s1=3'b101, s2=3'b100 -> next edge match=0, diff=3'b001, streak=0, alarm=0, total unchanged.
REQ-035 Saturation: hold s1=s2 for 300 samples -> streak sticks at 15 and total sticks at 255, with no wrap.
REQ-036 Priority: clr=1 and en=1 with s1=s2 while in LOCK -> next edge state IDLE and total=0, streak=0, alarm=0; en=0 mid-streak -> streak=0 and total held.
REQ-037 Async reset: assert rstn low between clock edges while in LOCK -> alarm, streak and total drop to 0 before the next edge.
